// File: rtl/lsu_dtcm_ctrl_pkg.sv
// Shared widths, size encodings and the outstanding-entry bundle
// for the LSU-to-DTCM datapath.
package lsu_dtcm_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int DTCM_RAM_AW = 16;
  localparam int RFIDX_WIDTH = 5;
  localparam int LANES = XLEN / 8;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef struct packed {
    logic                   read;
    logic [1:0]             size;
    logic                   usign;
    logic [1:0]             off;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic                   err;
  } outs_entry_t;

  // Word loads ignore the offset; byte/half shift the addressed lane down.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] rdata,
    input outs_entry_t     e
  );
    logic [XLEN-1:0] sh;
    sh = rdata >> {e.off, 3'b000};
    case (e.size)
      LSU_SIZE_B:
        load_extract = e.usign ?
          {{(XLEN-8){1'b0}}, sh[7:0]} :
          {{(XLEN-8){sh[7]}}, sh[7:0]};
      LSU_SIZE_H:
        load_extract = e.usign ?
          {{(XLEN-16){1'b0}}, sh[15:0]} :
          {{(XLEN-16){sh[15]}}, sh[15:0]};
      default:
        load_extract = rdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dtcm_ctrl_if.sv
// AGU request, DTCM cmd/rsp and EXU completion bundles of the LSU.
// slave = the LSU itself, master = EXU plus DTCM around it.
interface lsu_dtcm_ctrl_if;
  import lsu_dtcm_ctrl_pkg::*;

  logic                   agu_cmd_valid;
  logic                   agu_cmd_ready;
  logic                   agu_cmd_read;
  logic [XLEN-1:0]        agu_cmd_addr;
  logic [XLEN-1:0]        agu_cmd_wdata;
  logic [1:0]             agu_cmd_size;
  logic                   agu_cmd_usign;
  logic [RFIDX_WIDTH-1:0] agu_cmd_rdidx;

  logic                   lsu2dtcm_cmd_valid;
  logic                   lsu2dtcm_cmd_ready;
  logic                   lsu2dtcm_cmd_read;
  logic [DTCM_RAM_AW-1:0] lsu2dtcm_cmd_addr;
  logic [XLEN-1:0]        lsu2dtcm_cmd_wdata;
  logic [LANES-1:0]       lsu2dtcm_cmd_wmask;

  logic                   lsu2dtcm_rsp_valid;
  logic                   lsu2dtcm_rsp_ready;
  logic [XLEN-1:0]        lsu2dtcm_rsp_rdata;

  logic                   lsu_o_valid;
  logic                   lsu_o_ready;
  logic                   lsu_o_wbck_en;
  logic [XLEN-1:0]        lsu_o_wbck_wdat;
  logic [RFIDX_WIDTH-1:0] lsu_o_wbck_rdidx;
  logic                   lsu_o_err;

  modport slave (
    input  agu_cmd_valid, agu_cmd_read,
    input  agu_cmd_addr, agu_cmd_wdata,
    input  agu_cmd_size, agu_cmd_usign,
    input  agu_cmd_rdidx,
    output agu_cmd_ready,
    output lsu2dtcm_cmd_valid,
    output lsu2dtcm_cmd_read,
    output lsu2dtcm_cmd_addr,
    output lsu2dtcm_cmd_wdata,
    output lsu2dtcm_cmd_wmask,
    input  lsu2dtcm_cmd_ready,
    input  lsu2dtcm_rsp_valid,
    input  lsu2dtcm_rsp_rdata,
    output lsu2dtcm_rsp_ready,
    output lsu_o_valid, lsu_o_wbck_en,
    output lsu_o_wbck_wdat,
    output lsu_o_wbck_rdidx, lsu_o_err,
    input  lsu_o_ready
  );

  modport master (
    output agu_cmd_valid, agu_cmd_read,
    output agu_cmd_addr, agu_cmd_wdata,
    output agu_cmd_size, agu_cmd_usign,
    output agu_cmd_rdidx,
    input  agu_cmd_ready,
    input  lsu2dtcm_cmd_valid,
    input  lsu2dtcm_cmd_read,
    input  lsu2dtcm_cmd_addr,
    input  lsu2dtcm_cmd_wdata,
    input  lsu2dtcm_cmd_wmask,
    output lsu2dtcm_cmd_ready,
    output lsu2dtcm_rsp_valid,
    output lsu2dtcm_rsp_rdata,
    input  lsu2dtcm_rsp_ready,
    input  lsu_o_valid, lsu_o_wbck_en,
    input  lsu_o_wbck_wdat,
    input  lsu_o_wbck_rdidx, lsu_o_err,
    output lsu_o_ready
  );

endinterface

// File: rtl/lsu_outs_fifo.sv
// In-order tracker of outstanding LSU accesses.
// DEPTH must be a power of two, >= 1.
module lsu_outs_fifo
  import lsu_dtcm_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  outs_entry_t din,
  input  logic        pop,
  output outs_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  outs_entry_t   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          wr;
  logic          rd;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rptr];
  assign wr    = push & !full;
  assign rd    = pop & !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= din;
        wptr      <= nxt(wptr);
      end
      if (rd)
        rptr <= nxt(rptr);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/lsu_dtcm_ctrl.sv
// LSU datapath between EXU and DTCM: issue, in-order tracking, load extract.
// Define LSU_MISALGN_CHK_EN to trap misaligned half/word accesses.
module lsu_dtcm_ctrl
  import lsu_dtcm_ctrl_pkg::*;
#(
  parameter int OUTS_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_dtcm_ctrl_if.slave bus
);

  logic [1:0]       off;
  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             err_now;
  logic             open_q;
  logic             avail;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wb;
  logic [XLEN-1:0]  wdata;
  logic [LANES-1:0] wmask;
  outs_entry_t      wr_ent;
  outs_entry_t      head;
  logic             unused_ok;

  assign off     = bus.agu_cmd_addr[1:0];
  assign is_byte = bus.agu_cmd_size == LSU_SIZE_B;
  assign is_half = bus.agu_cmd_size == LSU_SIZE_H;
  assign is_word = !is_byte & !is_half;

`ifdef LSU_MISALGN_CHK_EN
  assign err_now = (is_half & off[0]) |
                   (is_word & (off != 2'b00));
`else
  assign err_now = 1'b0;
`endif

  always_comb begin
    wdata = bus.agu_cmd_wdata;
    wmask = '1;
    unique case (1'b1)
      is_byte: begin
        wdata = {LANES{bus.agu_cmd_wdata[7:0]}};
        wmask = LANES'(1) << off;
      end
      is_half: begin
        wdata = {(XLEN/16){bus.agu_cmd_wdata[15:0]}};
        wmask = LANES'(3) << {off[1], 1'b0};
      end
      is_word: begin
        wdata = bus.agu_cmd_wdata;
        wmask = '1;
      end
    endcase
  end

  // Hold the request side closed until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      open_q <= 1'b0;
    else
      open_q <= 1'b1;
  end

  assign avail = open_q & !full;

  assign bus.lsu2dtcm_cmd_valid =
    bus.agu_cmd_valid & avail & !err_now;
  assign bus.lsu2dtcm_cmd_read  = bus.agu_cmd_read;
  assign bus.lsu2dtcm_cmd_addr  =
    bus.agu_cmd_addr[DTCM_RAM_AW+1:2];
  assign bus.lsu2dtcm_cmd_wdata = wdata;
  assign bus.lsu2dtcm_cmd_wmask =
    bus.agu_cmd_read ? '0 : wmask;
  assign bus.agu_cmd_ready =
    avail & (err_now | bus.lsu2dtcm_cmd_ready);

  assign push = bus.agu_cmd_valid & bus.agu_cmd_ready;

  assign wr_ent = '{
    read:  bus.agu_cmd_read,
    size:  bus.agu_cmd_size,
    usign: bus.agu_cmd_usign,
    off:   off,
    rdidx: bus.agu_cmd_rdidx,
    err:   err_now
  };

  lsu_outs_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Error entries retire without a DTCM response.
  assign bus.lsu_o_valid =
    !empty & (head.err | bus.lsu2dtcm_rsp_valid);
  assign bus.lsu2dtcm_rsp_ready =
    !empty & !head.err & bus.lsu_o_ready;
  assign pop = bus.lsu_o_valid & bus.lsu_o_ready;

  assign wb = bus.lsu_o_valid & head.read & !head.err;
  assign bus.lsu_o_wbck_en   = wb;
  assign bus.lsu_o_wbck_wdat = wb ?
    load_extract(bus.lsu2dtcm_rsp_rdata, head) : '0;
  assign bus.lsu_o_wbck_rdidx =
    bus.lsu_o_valid ? head.rdidx : '0;

`ifdef LSU_MISALGN_CHK_EN
  assign bus.lsu_o_err = bus.lsu_o_valid & head.err;
`else
  assign bus.lsu_o_err = 1'b0;
`endif

  assign unused_ok =
    ^bus.agu_cmd_addr[XLEN-1:DTCM_RAM_AW+2];

endmodule
